// File: rtl/sam_pwm_decoder.sv
// Serially configured key/caps decoder for pulse-width-encoded bits.
// Each accepted symbol bit b yields msg = ({L{b}} ^ d) | caps over the L = 2^n low key bits.
module sam_pwm_decoder #(
    parameter int KEY_W      = 32,
    parameter int N_W        = 3,
    parameter int MIN_PERIOD = 10,
    parameter int MAX_PERIOD = 60,
    parameter int MSG_DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           str,
    input  logic                           mode,
    output logic [KEY_W-1:0]               msg,
    output logic                           msg_valid,
    output logic                           bit_out,
    output logic                           frame,
    output logic                           msg_done,
    output logic [$clog2(MSG_DEPTH+1)-1:0] sym_count,
    output logic                           configured,
    output logic                           err
);
    localparam int SC_W    = $clog2(MSG_DEPTH + 1);
    localparam int CNT_W   = $clog2(KEY_W + N_W + 1);
    localparam int PER_W   = $clog2(MAX_PERIOD + 1);
    localparam int LOG_KEY = $clog2(KEY_W);

    typedef enum logic [2:0] {IDLE, CFG_N, CFG_D, CFG_C, WAIT, SYM} state_t;

    state_t            state_reg, state_next, cur_state;
    logic              boot_reg;
    logic [N_W-1:0]    n_reg, n_next, n_shift;
    logic [KEY_W-1:0]  d_reg, d_next, caps_reg, caps_next;
    logic [KEY_W-1:0]  msg_reg, msg_next, decoded, key_mask;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, l_val;
    logic [PER_W-1:0]  hi_reg, hi_next, lo_reg, lo_next;
    logic [PER_W:0]    period;
    logic [SC_W-1:0]   count_reg, count_next;
    logic              str_q;
    logic              valid_reg, valid_next, bit_reg, bit_next;
    logic              frame_reg, frame_next, done_reg, done_next;
    logic              conf_reg, conf_next, err_reg, err_next;
    logic              rise, sym_bit, in_cfg, last_key_bit;

    // The first edge after reset behaves as CFG_N when mode is already high.
    assign cur_state    = (boot_reg && mode) ? CFG_N : state_reg;
    assign in_cfg       = (cur_state == CFG_N) || (cur_state == CFG_D) || (cur_state == CFG_C);
    assign rise         = str & ~str_q;
    assign l_val        = CNT_W'(1) << n_reg;
    assign key_mask     = ~({KEY_W{1'b1}} << l_val);
    assign last_key_bit = (cnt_reg == l_val - CNT_W'(1));
    assign n_shift      = N_W'({n_reg, str});
    assign period       = {1'b0, hi_reg} + {1'b0, lo_reg};
    assign sym_bit      = (hi_reg > lo_reg);

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_decode
        assign decoded[gi] = key_mask[gi] & ((sym_bit ^ d_reg[gi]) | caps_reg[gi]);
    end

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        d_next     = d_reg;
        caps_next  = caps_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        msg_next   = msg_reg;
        bit_next   = bit_reg;
        count_next = count_reg;
        frame_next = frame_reg;
        conf_next  = conf_reg;
        err_next   = err_reg;
        valid_next = 1'b0;
        done_next  = 1'b0;

        if (mode && !in_cfg) begin
            state_next = CFG_N;
            conf_next  = 1'b0;
            frame_next = 1'b0;
            cnt_next   = '0;
        end else if (in_cfg && !mode) begin
            state_next = IDLE;
            err_next   = 1'b1;
            cnt_next   = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (conf_reg) state_next = WAIT;
                end
                CFG_N: begin
                    n_next = n_shift;
                    if (cnt_reg == CNT_W'(N_W - 1)) begin
                        cnt_next = '0;
                        if (int'(n_shift) > LOG_KEY) begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            d_next     = '0;
                            caps_next  = '0;
                            state_next = CFG_D;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                CFG_D: begin
                    d_next = {d_reg[KEY_W-2:0], str} & key_mask;
                    if (last_key_bit) begin
                        cnt_next   = '0;
                        state_next = CFG_C;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                CFG_C: begin
                    caps_next = {caps_reg[KEY_W-2:0], str} & key_mask;
                    if (last_key_bit) begin
                        cnt_next   = '0;
                        conf_next  = 1'b1;
                        err_next   = 1'b0;
                        state_next = WAIT;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (rise) begin
                        frame_next = 1'b1;
                        count_next = '0;
                        hi_next    = PER_W'(1);
                        lo_next    = '0;
                        state_next = SYM;
                    end
                end
                SYM: begin
                    if (rise) begin
                        // The edge cycle is the first high cycle of the next symbol.
                        hi_next = PER_W'(1);
                        lo_next = '0;
                        if (period >= (PER_W+1)'(MIN_PERIOD)) begin
                            if (count_reg == SC_W'(MSG_DEPTH)) begin
                                err_next = 1'b1;
                            end else begin
                                msg_next   = decoded;
                                bit_next   = sym_bit;
                                valid_next = 1'b1;
                                count_next = count_reg + SC_W'(1);
                            end
                        end
                    end else if (str) begin
                        if (hi_reg != PER_W'(MAX_PERIOD)) hi_next = hi_reg + PER_W'(1);
                    end else if (lo_reg >= PER_W'(MAX_PERIOD - 1)) begin
                        lo_next    = PER_W'(MAX_PERIOD);
                        frame_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = WAIT;
                    end else begin
                        lo_next = lo_reg + PER_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            boot_reg  <= 1'b1;
            n_reg     <= '0;
            d_reg     <= '0;
            caps_reg  <= '0;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            msg_reg   <= '0;
            bit_reg   <= 1'b0;
            count_reg <= '0;
            str_q     <= 1'b0;
            valid_reg <= 1'b0;
            frame_reg <= 1'b0;
            done_reg  <= 1'b0;
            conf_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            boot_reg  <= 1'b0;
            n_reg     <= n_next;
            d_reg     <= d_next;
            caps_reg  <= caps_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            msg_reg   <= msg_next;
            bit_reg   <= bit_next;
            count_reg <= count_next;
            str_q     <= str;
            valid_reg <= valid_next;
            frame_reg <= frame_next;
            done_reg  <= done_next;
            conf_reg  <= conf_next;
            err_reg   <= err_next;
        end
    end

    assign msg        = msg_reg;
    assign msg_valid  = valid_reg;
    assign bit_out    = bit_reg;
    assign frame      = frame_reg;
    assign msg_done   = done_reg;
    assign sym_count  = count_reg;
    assign configured = conf_reg;
    assign err        = err_reg;
endmodule

// File: tb/tb_sam_pwm_decoder.sv
// Directed bench for sam_pwm_decoder: stimulus queues expectations, a negedge monitor checks them.
module tb_sam_pwm_decoder;
    localparam int KEY_W = 32;
    localparam int N_W   = 3;
    localparam int SC_W  = 5;

    localparam int F_MSG = 0, F_VALID = 1, F_BIT = 2, F_FRAME = 3;
    localparam int F_DONE = 4, F_SC = 5, F_CONF = 6, F_ERR = 7;

    logic             clk = 1'b0;
    logic             reset, str, mode;
    logic [KEY_W-1:0] msg;
    logic             msg_valid, bit_out, frame, msg_done, configured, err;
    logic [SC_W-1:0]  sym_count;

    sam_pwm_decoder dut (
        .clk(clk), .reset(reset), .str(str), .mode(mode),
        .msg(msg), .msg_valid(msg_valid), .bit_out(bit_out), .frame(frame),
        .msg_done(msg_done), .sym_count(sym_count), .configured(configured), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int sel; logic [31:0] val; string name; } exp_t;
    typedef struct { int cyc; logic [31:0] m; logic b; int cnt; } sb_t;
    exp_t exp_q[$];
    sb_t  sb_q[$];
    bit   finish_req = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] field(input int sel);
        case (sel)
            F_MSG:   return msg;
            F_VALID: return {31'b0, msg_valid};
            F_BIT:   return {31'b0, bit_out};
            F_FRAME: return {31'b0, frame};
            F_DONE:  return {31'b0, msg_done};
            F_SC:    return 32'(sym_count);
            F_CONF:  return {31'b0, configured};
            default: return {31'b0, err};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int sel, input logic [31:0] val, input string name);
        exp_q.push_back('{c, sel, val, name});
    endtask

    task automatic expect_now(input int sel, input logic [31:0] val, input string name);
        expect_at(cyc, sel, val, name);
    endtask

    task automatic expect_all_zero(input string tag);
        for (int s = 0; s < 8; s++) expect_now(s, 32'd0, $sformatf("%s_out%0d", tag, s));
    endtask

    // Called right before driving the rising edge that closes a valid symbol.
    task automatic expect_strobe(input logic [31:0] m, input logic b, input int cnt);
        sb_q.push_back('{cyc + 1, m, b, cnt});
    endtask

    task automatic symbol(input int hi_n, input int lo_n);
        str = 1'b1;
        repeat (hi_n) tick();
        str = 1'b0;
        repeat (lo_n) tick();
    endtask

    task automatic configure(input logic [N_W-1:0] nv, input int l, input logic [31:0] dv,
                             input logic [31:0] cv, input string tag);
        int c0;
        mode = 1'b1;
        str  = 1'b0;
        tick();
        c0 = cyc;
        expect_at(c0 + N_W + 2*l - 1, F_CONF, 32'd0, {tag, "_conf_early"});
        expect_at(c0 + N_W + 2*l, F_CONF, 32'd1, {tag, "_conf"});
        expect_at(c0 + N_W + 2*l, F_ERR, 32'd0, {tag, "_err_clr"});
        for (int i = N_W - 1; i >= 0; i--) begin str = nv[i]; tick(); end
        for (int i = l - 1; i >= 0; i--) begin str = dv[i]; tick(); end
        for (int i = l - 1; i >= 0; i--) begin str = cv[i]; tick(); end
        mode = 1'b0;
        str  = 1'b0;
        tick();
        tick();
    endtask

    // A short high run then a long low run: the open symbol times out.
    task automatic timeout_tail(input int hi_n, input int cnt, input string tag);
        str = 1'b1;
        repeat (hi_n) tick();
        str = 1'b0;
        repeat (59) tick();
        expect_now(F_FRAME, 32'd1, {tag, "_frame_pre"});
        expect_now(F_DONE, 32'd0, {tag, "_done_pre"});
        tick();
        expect_now(F_FRAME, 32'd0, {tag, "_frame_fall"});
        expect_now(F_DONE, 32'd1, {tag, "_done"});
        expect_now(F_SC, cnt, {tag, "_count"});
        tick();
        expect_now(F_DONE, 32'd0, {tag, "_done_once"});
        expect_now(F_SC, cnt, {tag, "_count_held"});
    endtask

    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                vectors++;
                if (exp_q[i].cyc < cyc || field(exp_q[i].sel) !== exp_q[i].val) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", exp_q[i].name, cyc,
                             field(exp_q[i].sel), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_missing cyc=%0d actual=none required=strobe@%0d msg=0x%0h",
                     cyc, sb_q[0].cyc, sb_q[0].m);
            void'(sb_q.pop_front());
        end
        if (msg_valid === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected cyc=%0d actual=msg 0x%0h required=no strobe", cyc, msg);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.cyc != cyc || msg !== e.m || bit_out !== e.b || int'(sym_count) != e.cnt) begin
                    miscompares++;
                    $display("FAIL strobe cyc=%0d actual=msg 0x%0h bit %0b count %0d required=cyc %0d msg 0x%0h bit %0b count %0d",
                             cyc, msg, bit_out, sym_count, e.cyc, e.m, e.b, e.cnt);
                end else begin
                    $display("strobe cyc=%0d msg=0x%0h bit=%0b count=%0d", cyc, msg, bit_out, sym_count);
                end
            end
        end
        if (finish_req) begin
            foreach (exp_q[i]) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_unchecked cyc=%0d actual=none required=0x%0h", exp_q[i].name, exp_q[i].cyc, exp_q[i].val);
            end
            foreach (sb_q[i]) begin
                vectors++;
                miscompares++;
                $display("FAIL strobe_never_seen actual=none required=msg 0x%0h at cyc %0d", sb_q[i].m, sb_q[i].cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        reset = 1'b1;
        str   = 1'b0;
        mode  = 1'b0;
        tick();
        tick();
        expect_all_zero("reset");
        reset = 1'b0;
        tick();

        // n = 6 asks for a 64-bit key on a 32-bit decoder.
        mode = 1'b1;
        tick();
        str = 1'b1; tick();
        str = 1'b1; tick();
        str = 1'b0; tick();
        mode = 1'b0;
        expect_now(F_ERR, 32'd1, "bad_n_err");
        expect_now(F_CONF, 32'd0, "bad_n_conf");
        tick();
        tick();
        expect_now(F_ERR, 32'd1, "err_sticky");

        // L = 4, d = 1010, caps = 0001: b=1 -> 0x5, b=0 -> 0xB.
        configure(3'b010, 4, 32'hA, 32'h1, "cfg4");

        // Message A: two valid symbols then a timeout.
        expect_at(cyc + 1, F_FRAME, 32'd1, "a_frame_rise");
        expect_at(cyc + 1, F_SC, 32'd0, "a_count_start");
        symbol(8, 4);
        expect_now(F_FRAME, 32'd1, "a_frame_hold");
        expect_now(F_VALID, 32'd0, "a_no_early_strobe");
        expect_strobe(32'h5, 1'b1, 1);
        symbol(3, 9);
        expect_strobe(32'hB, 1'b0, 2);
        timeout_tail(4, 2, "a_timeout");

        // Message B: tie, glitch, valid, timeout.
        expect_at(cyc + 1, F_SC, 32'd0, "b_restart_count");
        expect_at(cyc + 1, F_FRAME, 32'd1, "b_restart_frame");
        symbol(6, 6);
        expect_strobe(32'hB, 1'b0, 1);
        symbol(2, 3);
        expect_at(cyc + 1, F_VALID, 32'd0, "glitch_no_strobe");
        expect_at(cyc + 1, F_SC, 32'd1, "glitch_count");
        expect_at(cyc + 1, F_MSG, 32'hB, "glitch_msg_held");
        symbol(8, 4);
        expect_strobe(32'h5, 1'b1, 2);
        timeout_tail(3, 2, "b_timeout");

        // Message C: 17 valid symbols overflow a 16-deep message.
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                expect_strobe(((i - 1) % 2 == 0) ? 32'h5 : 32'hB, ((i - 1) % 2 == 0), i);
                if (i == 16) expect_at(cyc + 1, F_ERR, 32'd0, "err_before_overflow");
            end
            if (i % 2 == 0) symbol(8, 4);
            else symbol(3, 9);
        end
        expect_at(cyc + 1, F_ERR, 32'd1, "overflow_err");
        expect_at(cyc + 1, F_SC, 32'd16, "overflow_count");
        expect_at(cyc + 1, F_VALID, 32'd0, "overflow_no_strobe");
        str = 1'b1;
        repeat (3) tick();

        // Asynchronous reset in the middle of a symbol.
        #2;
        reset = 1'b1;
        mode  = 1'b0;
        str   = 1'b0;
        expect_all_zero("rst_sym");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Mode falls after the fifth configuration bit.
        mode = 1'b1;
        tick();
        str = 1'b0; tick();
        str = 1'b1; tick();
        str = 1'b0; tick();
        str = 1'b1; tick();
        str = 1'b0; tick();
        expect_now(F_ERR, 32'd0, "abort_err_before");
        mode = 1'b0;
        tick();
        expect_now(F_ERR, 32'd1, "abort_err");
        expect_now(F_CONF, 32'd0, "abort_conf");
        tick();

        // Asynchronous reset in the middle of CFG_D.
        mode = 1'b1;
        tick();
        str = 1'b0; tick();
        str = 1'b1; tick();
        str = 1'b0; tick();
        str = 1'b1; tick();
        str = 1'b0; tick();
        #2;
        reset = 1'b1;
        mode  = 1'b0;
        expect_all_zero("rst_cfg");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Fresh configuration, L = 8, d = 0xC3, caps = 0x10: b=1 -> 0x3C, b=0 -> 0xD3.
        configure(3'b011, 8, 32'hC3, 32'h10, "cfg8");
        symbol(9, 3);
        expect_strobe(32'h3C, 1'b1, 1);
        symbol(4, 8);
        expect_strobe(32'hD3, 1'b0, 2);
        str = 1'b1;
        tick();
        tick();
        finish_req = 1'b1;
        repeat (3) tick();
    end
endmodule
